// File: rtl/iguana_rst_strap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iguana_rst_strap_ctrl
// Brief    : Pad-reset stretcher and boot-strap sampler. Releases the SoC
//            reset with a latched boot_mode, then the HyperBus PHY reset.
// Revision : 1.0 - initial release
// ============================================================================
module iguana_rst_strap_ctrl #(
    parameter int RST_STRETCH_CYCLES   = 32,
    parameter int SYNC_STAGES          = 2,
    parameter int STRAP_STABLE_CYCLES  = 8,
    parameter int STRAP_TIMEOUT_CYCLES = 256,
    parameter int HYP_RST_DELAY_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       testmode_i,
    input  logic [1:0] boot_mode_pad_i,
    input  logic       sw_rst_req_i,
    output logic       rst_soc_no,
    output logic       rst_hyp_no,
    output logic [1:0] boot_mode_o,
    output logic       boot_mode_valid_o,
    output logic       strap_err_o
);

    localparam int c_MAX_A   = (RST_STRETCH_CYCLES > HYP_RST_DELAY_CYCLES) ?
                               RST_STRETCH_CYCLES : HYP_RST_DELAY_CYCLES;
    localparam int c_CNT_MAX = (c_MAX_A > STRAP_TIMEOUT_CYCLES) ? c_MAX_A : STRAP_TIMEOUT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_STB_W   = $clog2(STRAP_STABLE_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_SAT   = c_CNT_W'(c_CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(RST_STRETCH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST  = c_CNT_W'(STRAP_TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HYP_LAST  = c_CNT_W'(HYP_RST_DELAY_CYCLES - 1);
    localparam logic [c_STB_W-1:0] c_STB_SAT   = c_STB_W'(STRAP_STABLE_CYCLES);
    localparam logic [c_STB_W-1:0] c_STB_LAST  = c_STB_W'(STRAP_STABLE_CYCLES - 1);

    localparam logic [1:0] c_ST_HOLD   = 2'd0;
    localparam logic [1:0] c_ST_SAMPLE = 2'd1;
    localparam logic [1:0] c_ST_SOC_UP = 2'd2;
    localparam logic [1:0] c_ST_RUN    = 2'd3;

    logic [2*SYNC_STAGES-1:0] r_sync;
    logic [1:0]               r_strap_prev;
    logic [1:0]               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [c_STB_W-1:0]       r_stable, w_stable_nxt, w_stable_inc;
    logic                     r_soc, w_soc_nxt;
    logic                     r_hyp, w_hyp_nxt;
    logic                     r_valid, w_valid_nxt;
    logic                     r_err, w_err_nxt;
    logic [1:0]               r_boot, w_boot_nxt;
    logic [1:0]               w_strap_sync;
    logic                     w_equal;

    assign w_strap_sync = r_sync[2*SYNC_STAGES-1 -: 2];
    assign w_equal      = (w_strap_sync == r_strap_prev);
    assign w_cnt_inc    = (r_cnt == c_CNT_SAT) ? r_cnt : r_cnt + 1'b1;
    assign w_stable_inc = (r_stable == c_STB_SAT) ? r_stable : r_stable + 1'b1;

    // Previous-sample register runs every cycle so SAMPLE can compare on its first edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync       <= '0;
            r_strap_prev <= '0;
        end else begin
            r_sync       <= {r_sync[2*SYNC_STAGES-3:0], boot_mode_pad_i};
            r_strap_prev <= w_strap_sync;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= c_ST_HOLD;
            r_cnt    <= '0;
            r_stable <= '0;
            r_soc    <= 1'b0;
            r_hyp    <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_boot   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_stable <= w_stable_nxt;
            r_soc    <= w_soc_nxt;
            r_hyp    <= w_hyp_nxt;
            r_valid  <= w_valid_nxt;
            r_err    <= w_err_nxt;
            r_boot   <= w_boot_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        w_soc_nxt    = r_soc;
        w_hyp_nxt    = r_hyp;
        w_valid_nxt  = r_valid;
        w_err_nxt    = r_err;
        w_boot_nxt   = r_boot;
        case (r_state)
            c_ST_HOLD: begin
                w_soc_nxt = 1'b0;
                w_hyp_nxt = 1'b0;
                if (r_cnt == c_HOLD_LAST) begin
                    w_state_nxt  = c_ST_SAMPLE;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            c_ST_SAMPLE: begin
                w_cnt_nxt    = w_cnt_inc;
                w_stable_nxt = w_equal ? w_stable_inc : '0;
                // Stable completion is checked first so it wins a same-cycle timeout.
                if (w_equal && (r_stable == c_STB_LAST)) begin
                    w_state_nxt = c_ST_SOC_UP;
                    w_cnt_nxt   = '0;
                    w_boot_nxt  = w_strap_sync;
                    w_valid_nxt = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_soc_nxt   = 1'b1;
                end else if (r_cnt == c_TMO_LAST) begin
                    w_state_nxt = c_ST_SOC_UP;
                    w_cnt_nxt   = '0;
                    w_boot_nxt  = w_strap_sync;
                    w_valid_nxt = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_soc_nxt   = 1'b1;
                end
            end
            c_ST_SOC_UP: begin
                if (sw_rst_req_i) begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_nxt   = '0;
                    w_soc_nxt   = 1'b0;
                    w_hyp_nxt   = 1'b0;
                    w_valid_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                end else if (r_cnt == c_HYP_LAST) begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = '0;
                    w_hyp_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                if (sw_rst_req_i) begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_nxt   = '0;
                    w_soc_nxt   = 1'b0;
                    w_hyp_nxt   = 1'b0;
                    w_valid_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                end
            end
        endcase
    end

    // DFT bypass: resets follow the pad reset, straps pass straight through.
    assign rst_soc_no        = testmode_i ? ~rst_i          : r_soc;
    assign rst_hyp_no        = testmode_i ? ~rst_i          : r_hyp;
    assign boot_mode_o       = testmode_i ? boot_mode_pad_i : r_boot;
    assign boot_mode_valid_o = testmode_i ? 1'b1            : r_valid;
    assign strap_err_o       = testmode_i ? 1'b0            : r_err;

endmodule
`default_nettype wire

// File: doc/iguana_rst_strap_ctrl.md
# iguana_rst_strap_ctrl

Reset sequencer and boot-strap sampler that sits directly upstream of the Iguana top level. It takes the raw pad reset and the `boot_mode` strap pads, stretches the reset, and samples the straps until they are stable. It then releases the SoC reset with a latched `boot_mode`, and releases the HyperBus PHY reset a fixed number of cycles later. It also re-runs the whole sequence on a software reset request.

## Interface
Parameters:
- `RstStretchCycles`, 32: cycles spent in HOLD after pad reset deasserts; must be ≥1.
- `SyncStages`, 2: depth of the strap synchronizer; must be ≥2.
- `StrapStableCycles`, 8: number of consecutive identical synchronized samples required to accept the straps; must be ≥1.
- `StrapTimeoutCycles`, 256: maximum number of cycles spent in SAMPLE; must be greater than `StrapStableCycles`.
- `HypRstDelayCycles`, 16: delay from SoC reset release to HyperBus reset release; must be ≥1.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: pad reset, asynchronous, active-high.
- `testmode_i`, in, 1: DFT bypass.
- `boot_mode_pad_i`, in, 2: raw strap pads, asynchronous.
- `sw_rst_req_i`, in, 1: single-cycle software reset request.
- `rst_soc_no`, out, 1: SoC reset, active-low; drives the top's `rst_ni`.
- `rst_hyp_no`, out, 1: PHY reset, active-low; drives `hyp_rst_phy_ni`.
- `boot_mode_o`, out, 2: latched strap value; drives `boot_mode_i`.
- `boot_mode_valid_o`, out, 1: `boot_mode_o` is latched.
- `strap_err_o`, out, 1: SAMPLE timed out before the straps were stable.

## Operation
- All state is in flops cleared asynchronously by `rst_i`. Reset value of every output is 0, and the FSM is in HOLD.
- Strap path: `boot_mode_pad_i` passes through a `SyncStages`-deep flop chain (reset value 0), giving `strap_sync`.
- FSM states:
  - **HOLD**: the counter counts `RstStretchCycles` cycles, then the FSM goes to SAMPLE. Both resets are low.
  - **SAMPLE**: each cycle, `strap_sync` is compared with the previous sample.
    - Equal: `stable_cnt` increments. Different: `stable_cnt` clears to 0.
    - When `StrapStableCycles` consecutive equal samples have been seen, `boot_mode_o` latches `strap_sync`, `boot_mode_valid_o` is set to 1, and the FSM goes to SOC_UP.
    - If `StrapTimeoutCycles` is reached first, the current `strap_sync` is latched anyway, `strap_err_o` is set to 1, and the FSM goes to SOC_UP.
    - If stable-count completion and timeout occur on the same cycle, the stable path wins and `strap_err_o` stays 0.
  - **SOC_UP**: `rst_soc_no` is 1. The counter counts `HypRstDelayCycles` cycles, then the FSM goes to RUN.
  - **RUN**: both resets are 1.
- `sw_rst_req_i` is honoured in RUN and SOC_UP only. On the next edge:
  - state goes to HOLD;
  - `rst_soc_no`, `rst_hyp_no`, `boot_mode_valid_o` and `strap_err_o` go to 0;
  - `boot_mode_o` keeps its last value until the next latch.
- `sw_rst_req_i` is ignored in HOLD and SAMPLE.
- `rst_i` asserted mid-sequence: every output goes to 0 immediately (asynchronously) and the sequence restarts from HOLD after release.
- `testmode_i`=1:
  - `rst_soc_no` = `rst_hyp_no` = `~rst_i`, combinationally;
  - `boot_mode_o` = `boot_mode_pad_i`;
  - `boot_mode_valid_o` = 1;
  - the FSM keeps running internally, but its outputs are masked.
- All counters saturate and never wrap. Each counter is `$clog2(max+1)` bits wide.

## Timing
- Cycle 1 is the first rising edge with `rst_i` low.
- HOLD occupies cycles 1..`RstStretchCycles`.
- Strap latch: with stable pads, the latch happens `StrapStableCycles` cycles after SAMPLE entry. `rst_soc_no` and `boot_mode_valid_o` rise on the same edge.
  - Defaults: `rst_soc_no` rises at edge 40.
- `rst_hyp_no` rises exactly `HypRstDelayCycles` edges after `rst_soc_no` (edge 56 with defaults).
- Software reset: resets fall one edge after `sw_rst_req_i` is sampled high. The full sequence then repeats: `rst_soc_no` rises again 1+32+8 edges after the request (defaults).
- Every output except the testmode bypass is driven directly from a flop.

## Test plan
- **Power-on, stable straps**: hold `boot_mode_pad_i`=2'b10, release `rst_i` -> `rst_soc_no` rises at edge 40, `boot_mode_o`=2'b10, `boot_mode_valid_o`=1, `rst_hyp_no` rises at edge 56, `strap_err_o`=0.
- **Glitchy straps**: toggle the pads every 3 cycles for 100 cycles, then hold 2'b01 -> latch occurs exactly 8 synchronized-stable cycles after the last toggle, `boot_mode_o`=2'b01, no error.
- **Strap timeout**: toggle the pads every 2 cycles forever -> after 256 SAMPLE cycles `strap_err_o`=1, `rst_soc_no` rises, and `boot_mode_o` equals `strap_sync` at that edge.
- **Software reset**: pulse `sw_rst_req_i` in RUN with the pads changed to 2'b11 -> next edge: both resets at 0 and `valid`=0; later the sequence re-latches 2'b11.
- **Mid-sequence pad reset**: assert `rst_i` during SOC_UP -> all outputs go to 0 without waiting for a clock edge; after release, full timing repeats from edge 1.
- **Testmode**: `testmode_i`=1, toggle `rst_i` -> `rst_soc_no`/`rst_hyp_no` track `~rst_i` combinationally and `boot_mode_o` tracks the pads.
